// File: rtl/seq_match_pkg.sv
// seq_match_pkg: shared definitions for the serial pattern matcher.
//   state_t     : run-controller FSM states (IDLE/ARM/RUN/DONE)
//   STATE_W     : width of the state encoding
//   PAT_RST_DEF : default pattern loaded by clr
package seq_match_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'b00,
        ST_ARM  = 2'b01,
        ST_RUN  = 2'b11,
        ST_DONE = 2'b10
    } state_t;

    localparam logic [2:0] PAT_RST_DEF = 3'b101;

endpackage

// File: rtl/seq_window.sv
// seq_window: match window for seq_match_ctrl.
//   A shift register that holds the most recent bits (the MSB is the oldest), a
//   fill counter that tracks how many fresh bits have entered since the last
//   clear, and the comparator.
// Ports:
//   clk, clr   clock / synchronous active-high reset
//   shift      take x into the window this cycle
//   clear      drop the window contents and the fill count (has priority over shift)
//   x          serial data bit
//   pattern    pattern to compare against
//   full       the window is full once this cycle's bit is in
//   hit        this cycle's bit completes a full window equal to pattern
module seq_window #(
    parameter int PAT_W = 3
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             shift,
    input  logic             clear,
    input  logic             x,
    input  logic [PAT_W-1:0] pattern,
    output logic             full,
    output logic             hit
);

    localparam int FILL_W = $clog2(PAT_W + 1);

    logic [PAT_W-1:0]  window;
    logic [PAT_W-1:0]  win_nxt;
    logic [FILL_W-1:0] fill;

    assign win_nxt = {window[PAT_W-2:0], x};

    // With PAT_W-1 bits already in place, the incoming bit completes the window.
    assign full = (fill >= FILL_W'(PAT_W - 1));
    assign hit  = shift && full && (win_nxt == pattern);

    always_ff @(posedge clk) begin
        if (clr || clear) begin
            window <= '0;
            fill   <= '0;
        end else if (shift) begin
            window <= win_nxt;
            if (fill != FILL_W'(PAT_W))
                fill <= fill + 1'b1;
        end
    end

endmodule

// File: rtl/seq_match_ctrl.sv
// seq_match_ctrl: run controller for a serial bit-pattern matcher.
//   Holds a configurable pattern, arms on start, shifts qualified bits into a
//   match window, counts matches, and stops on reaching the target count, on
//   stop, or (optionally) on timeout.
// Optional feature: define SEQ_MATCH_TIMEOUT_EN to enable the idle-cycle
//   timeout (TIMEOUT_CYC busy cycles without a match abort the run). Without
//   it, timeout is tied to 0.
// Ports:
//   clk, clr      clock / synchronous active-high reset
//   cfg_we        config write strobe (taken in IDLE and DONE only)
//   cfg_pattern   pattern to match, MSB = oldest bit
//   cfg_overlap   1: overlapping matches allowed
//   cfg_target    match count that ends the run, 0 = run until stop
//   start, stop   begin a run / abort a run
//   x, x_valid    serial data bit and its qualifier
//   match         1-cycle pulse, the cycle after the completing bit
//   match_cnt     matches in this run, saturating
//   busy, done    state levels (ARM/RUN, DONE)
//   timeout       set on a timeout abort, cleared by start or clr
module seq_match_ctrl
    import seq_match_pkg::*;
#(
    parameter int               PAT_W       = 3,
    parameter logic [PAT_W-1:0] PAT_RST     = PAT_W'(PAT_RST_DEF),
    parameter int               CNT_W       = 8,
    parameter int               TIMEOUT_CYC = 1000
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic             cfg_overlap,
    input  logic [CNT_W-1:0] cfg_target,
    input  logic             start,
    input  logic             stop,
    input  logic             x,
    input  logic             x_valid,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             busy,
    output logic             done,
    output logic             timeout
);

    state_t           state, state_nxt;
    logic [PAT_W-1:0] pat_q;
    logic             ovl_q;
    logic [CNT_W-1:0] tgt_q;

    logic             idle_s, busy_s;
    logic             run_start, stop_acc, shift, win_clear;
    logic             full, hit, tgt_hit, tmo;
    logic [CNT_W-1:0] cnt_inc;

    assign busy_s    = (state == ST_ARM) || (state == ST_RUN);
    assign idle_s    = !busy_s;
    assign run_start = start && idle_s;
    assign stop_acc  = stop && busy_s;
    // stop drops a same-cycle bit, so it can never produce a match.
    assign shift     = x_valid && busy_s && !stop;

    assign cnt_inc = (match_cnt == '1) ? match_cnt : match_cnt + 1'b1;
    assign tgt_hit = hit && (tgt_q != '0) && (cnt_inc == tgt_q);

    // Without overlap a match consumes the window: PAT_W fresh bits are needed.
    assign win_clear = run_start || stop_acc || tmo || (hit && !ovl_q);

    seq_window #(.PAT_W(PAT_W)) u_win (
        .clk     (clk),
        .clr     (clr),
        .shift   (shift),
        .clear   (win_clear),
        .x       (x),
        .pattern (pat_q),
        .full    (full),
        .hit     (hit)
    );

`ifdef SEQ_MATCH_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tcnt;

    always_ff @(posedge clk) begin
        if (clr || run_start || hit || !busy_s)
            tcnt <= '0;
        else
            tcnt <= tcnt + 1'b1;
    end

    // A match on the expiring cycle restarts the count; stop wins over expiry.
    assign tmo = busy_s && !stop && !hit && (tcnt == TMO_W'(TIMEOUT_CYC - 1));
`else
    assign tmo = 1'b0;
`endif

    // FSM: state register
    always_ff @(posedge clk) begin
        if (clr)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE, ST_DONE: begin
                if (start)
                    state_nxt = ST_ARM;
            end
            ST_ARM, ST_RUN: begin
                if (stop || tmo)
                    state_nxt = ST_IDLE;
                else if (tgt_hit)
                    state_nxt = ST_DONE;
                else if (hit && !ovl_q)
                    state_nxt = ST_ARM;
                else if (shift && full)
                    state_nxt = ST_RUN;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state)
            ST_ARM, ST_RUN: busy = 1'b1;
            ST_DONE:        done = 1'b1;
            default:        ;
        endcase
    end

    // Config is frozen while a run is in progress.
    always_ff @(posedge clk) begin
        if (clr) begin
            pat_q <= PAT_RST;
            ovl_q <= 1'b1;
            tgt_q <= '0;
        end else if (cfg_we && idle_s) begin
            pat_q <= cfg_pattern;
            ovl_q <= cfg_overlap;
            tgt_q <= cfg_target;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            match     <= 1'b0;
            match_cnt <= '0;
            timeout   <= 1'b0;
        end else begin
            match <= hit;
            if (run_start)
                match_cnt <= '0;
            else if (hit)
                match_cnt <= cnt_inc;
            if (run_start)
                timeout <= 1'b0;
            else if (tmo)
                timeout <= 1'b1;
        end
    end

endmodule
